// File: rtl/board_scanner_pkg.sv
// Shared definitions for the board scanner: cell and winner codes, line table, FSM states.
package board_scanner_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_PL1   = 2'b01;
  localparam logic [1:0] CELL_PL2   = 2'b10;
  localparam logic [1:0] CELL_BAD   = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_PL1  = 2'b01;
  localparam logic [1:0] WIN_PL2  = 2'b10;

  // Zero-based cell indices (pos1 = 0) for each of the eight lines, in report order.
  localparam logic [3:0] LINE_TABLE [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  typedef enum logic {IDLE, SCAN} state_t;

endpackage

// File: rtl/board_line_eval.sv
// Combinational check of one line: wins when all three cells match and hold a player code.
module board_line_eval
  import board_scanner_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  output logic       win,
  output logic [1:0] code
);

  assign win  = (a == b) && (b == c) && (a != CELL_EMPTY) && (a != CELL_BAD);
  assign code = win ? a : WIN_NONE;

endmodule

// File: rtl/board_scanner.sv
// Snapshots the board on start and scans the eight lines for a result.
// BOARD_SCAN_FAST_EN: evaluate all lines in a single cycle instead of one per cycle.
module board_scanner
  import board_scanner_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic [2:0] win_line,
  output logic       draw,
  output logic       illegal
);

  state_t           state;
  logic [8:0][1:0]  snap;
  logic             any_bad;
  logic             full;
  logic             bad_check;
  logic             hit;
  logic [2:0]       hit_idx;
  logic [1:0]       hit_code;
  logic             last;

  always_comb begin
    any_bad = 1'b0;
    full    = 1'b1;
    for (int unsigned i = 0; i < 9; i++) begin
      if (snap[i] == CELL_BAD)   any_bad = 1'b1;
      if (snap[i] == CELL_EMPTY) full    = 1'b0;
    end
  end

`ifdef BOARD_SCAN_FAST_EN
  logic [7:0]      wins;
  logic [7:0][1:0] codes;

  for (genvar g = 0; g < 8; g++) begin : g_line
    board_line_eval u_eval (
      .a    (snap[LINE_TABLE[g][0]]),
      .b    (snap[LINE_TABLE[g][1]]),
      .c    (snap[LINE_TABLE[g][2]]),
      .win  (wins[g]),
      .code (codes[g])
    );
  end

  // First set bit wins so the lowest-index line is reported.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_code = WIN_NONE;
    for (int unsigned i = 0; i < 8; i++) begin
      if (wins[i] && !hit) begin
        hit      = 1'b1;
        hit_idx  = 3'(i);
        hit_code = codes[i];
      end
    end
  end

  assign bad_check = any_bad;
  assign last      = 1'b1;
`else
  logic [2:0] idx;

  board_line_eval u_eval (
    .a    (snap[LINE_TABLE[idx][0]]),
    .b    (snap[LINE_TABLE[idx][1]]),
    .c    (snap[LINE_TABLE[idx][2]]),
    .win  (hit),
    .code (hit_code)
  );

  assign hit_idx   = idx;
  assign bad_check = (idx == 3'd0) && any_bad;
  assign last      = (idx == 3'd7);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      snap     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      winner   <= WIN_NONE;
      win_line <= '0;
      draw     <= 1'b0;
      illegal  <= 1'b0;
`ifndef BOARD_SCAN_FAST_EN
      idx      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap  <= {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
            busy  <= 1'b1;
            state <= SCAN;
`ifndef BOARD_SCAN_FAST_EN
            idx   <= '0;
`endif
          end
        end
        SCAN: begin
          if (bad_check || hit || last) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
            illegal  <= bad_check;
            winner   <= (!bad_check && hit) ? hit_code : WIN_NONE;
            win_line <= (!bad_check && hit) ? hit_idx : '0;
            draw     <= !bad_check && !hit && full;
          end
`ifndef BOARD_SCAN_FAST_EN
          else begin
            idx <= idx + 3'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_scanner.sv
// Randomized and directed bench for board_scanner against a rule-level reference model.
module tb_board_scanner;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic       busy, done, draw, illegal;
  logic [1:0] winner;
  logic [2:0] win_line;

  int checks = 0;
  int errors = 0;
  logic [1:0] board [9];

  localparam int LINES [8][3] = '{
    '{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7}, '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}
  };

  board_scanner dut (
    .clock(clock), .reset(reset), .start(start),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .busy(busy), .done(done), .winner(winner), .win_line(win_line),
    .draw(draw), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result and latency (edges after the start edge) derived straight from the game rules.
  task automatic model(output logic [1:0] ew, output logic [2:0] el,
                       output logic ed, output logic ei, output int elat);
    int first = -1;
    bit bad = 0, fullb = 1;
    for (int c = 0; c < 9; c++) begin
      if (board[c] == 2'b11) bad = 1;
      if (board[c] == 2'b00) fullb = 0;
    end
    for (int l = 7; l >= 0; l--) begin
      logic [1:0] x;
      x = board[LINES[l][0]-1];
      if (x != 2'b00 && x != 2'b11 && x == board[LINES[l][1]-1] && x == board[LINES[l][2]-1])
        first = l;
    end
    ei = bad;
    ew = (!bad && first >= 0) ? board[LINES[first][0]-1] : 2'b00;
    el = (!bad && first >= 0) ? 3'(first) : 3'd0;
    ed = !bad && first < 0 && fullb;
`ifdef BOARD_SCAN_FAST_EN
    elat = 1;
`else
    elat = bad ? 1 : (first >= 0 ? first + 1 : 8);
`endif
  endtask

  task automatic drive_board();
    pos1 = board[0]; pos2 = board[1]; pos3 = board[2];
    pos4 = board[3]; pos5 = board[4]; pos6 = board[5];
    pos7 = board[6]; pos8 = board[7]; pos9 = board[8];
  endtask

  task automatic do_scan(input string tag, input bit disturb);
    logic [1:0] ew; logic [2:0] el; logic ed, ei; int elat; int lat;
    model(ew, el, ed, ei, elat);
    drive_board();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, ".busy_on"}, busy, 1);
    if (disturb) begin
      pos2  = 2'b00;
      start = 1'b1;
    end
    lat = 0;
    do begin
      @(posedge clock); #1;
      start = 1'b0;
      lat++;
    end while (!done && lat < 20);
    check({tag, ".latency"}, lat, elat);
    check({tag, ".winner"}, winner, ew);
    check({tag, ".win_line"}, win_line, el);
    check({tag, ".draw"}, draw, ed);
    check({tag, ".illegal"}, illegal, ei);
    check({tag, ".busy_off"}, busy, 0);
    @(posedge clock); #1;
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".no_requeue"}, busy, 0);
  endtask

  task automatic set_board(input logic [17:0] cells);
    for (int c = 0; c < 9; c++) board[c] = cells[2*(8-c) +: 2];
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    set_board('0); drive_board();
    repeat (3) @(posedge clock);
    #1;
    check("rst.busy", busy, 0);   check("rst.done", done, 0);
    check("rst.winner", winner, 0); check("rst.win_line", win_line, 0);
    check("rst.draw", draw, 0);   check("rst.illegal", illegal, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    set_board('0);
    do_scan("empty", 0);
    set_board({2'd0,2'd0,2'd0, 2'd0,2'd0,2'd0, 2'd2,2'd2,2'd2});
    do_scan("row3_pl2", 0);

    // Abort a line-7 scan with reset (start held alongside it must be ignored).
    set_board({2'd0,2'd0,2'd2, 2'd0,2'd2,2'd0, 2'd2,2'd0,2'd0});
    drive_board();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0;
    check("abort.busy", busy, 0);    check("abort.done", done, 0);
    check("abort.winner", winner, 0); check("abort.win_line", win_line, 0);
    check("abort.draw", draw, 0);    check("abort.illegal", illegal, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      check("abort.quiet", {30'd0, busy, done}, 0);
    end

    set_board({2'd1,2'd2,2'd1, 2'd1,2'd2,2'd2, 2'd2,2'd1,2'd1});
    do_scan("draw", 0);
    set_board({2'd0,2'd0,2'd0, 2'd0,2'd3,2'd0, 2'd0,2'd0,2'd0});
    do_scan("bad_center", 0);
    set_board({2'd1,2'd0,2'd2, 2'd0,2'd0,2'd0, 2'd0,2'd0,2'd0});
    do_scan("clean", 0);
    set_board({2'd1,2'd1,2'd1, 2'd0,2'd1,2'd2, 2'd2,2'd0,2'd1});
    do_scan("snapshot", 1);

    for (int t = 0; t < 60; t++) begin
      for (int c = 0; c < 9; c++)
        board[c] = ($urandom_range(0, 99) < 3) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        int l; logic [1:0] code;
        l = $urandom_range(0, 7);
        code = 2'($urandom_range(1, 2));
        for (int k = 0; k < 3; k++) board[LINES[l][k]-1] = code;
      end
      do_scan($sformatf("rand%0d", t), t[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
